rom_sample_player: RTL

- Sequences reads from the single-port music block ROM (W-bit rows, L deep, 1-cycle registered read) and streams samples to the I2S transmitter over a valid/ready handshake.
- Plays a configurable address segment once or looped.
- Sits between the ROM instance (external to this block) and the I2S serializer.
- Owns the ROM address bus exclusively.

---
 rtl/rom_sample_player_pkg.sv | 19 +
 rtl/rom_sample_player_if.sv | 40 ++++
 rtl/rom_sample_player.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/rom_sample_player_pkg.sv
// -----------------------------------------------------------------------------
// rom_player_pkg
// Shared types for the ROM sample player.
//   state_t : playback sequencer states
//     S_IDLE    - waiting for a start pulse
//     S_FETCH   - ROM address stable, ROM registers the row at the closing edge
//     S_CAPTURE - ROM data available, copied into the sample register
//     S_PRESENT - sample offered downstream until it is accepted
// -----------------------------------------------------------------------------
package rom_player_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_CAPTURE = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

endpackage : rom_player_pkg

// File: rtl/rom_sample_player_if.sv
// -----------------------------------------------------------------------------
// rom_sample_player_if
// Bundles the two buses owned by the sample player:
//   ROM side    : rom_addr (player -> ROM), rom_rd_data (ROM -> player)
//   Stream side : sample, sample_valid (player -> I2S), sample_ready (I2S -> player)
// Modports:
//   master : the player (drives rom_addr/sample/sample_valid)
//   slave  : the environment, i.e. ROM + I2S serializer
// Parameters:
//   W  : sample / ROM row width
//   AW : ROM address width
// -----------------------------------------------------------------------------
interface rom_sample_player_if #(
    parameter int W  = 8,
    parameter int AW = 5
);

    logic [AW-1:0] rom_addr;
    logic [W-1:0]  rom_rd_data;
    logic [W-1:0]  sample;
    logic          sample_valid;
    logic          sample_ready;

    modport master (
        output rom_addr,
        input  rom_rd_data,
        output sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  rom_addr,
        output rom_rd_data,
        input  sample,
        input  sample_valid,
        output sample_ready
    );

endinterface : rom_sample_player_if

// File: rtl/rom_sample_player.sv
// -----------------------------------------------------------------------------
// rom_sample_player
// Walks an address segment of the external music ROM (1-cycle registered read)
// and streams each row to the I2S transmitter over valid/ready. The segment is
// played once (done pulses at the end) or looped until stop.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : pulse, latches start_addr/end_addr/loop and starts play
//   stop            : pulse, aborts play (no done)
//   start_addr      : first address of the segment
//   end_addr        : last address of the segment (inclusive, may wrap)
//   loop            : restart at start_addr after end_addr
//   busy            : sequencer not idle
//   done            : one-cycle pulse when a non-looped segment finishes
//   bus (master)    : rom_addr / rom_rd_data / sample / sample_valid / sample_ready
//
// Throughput is one sample per three clocks: FETCH, CAPTURE, PRESENT.
// -----------------------------------------------------------------------------
module rom_sample_player
    import rom_player_pkg::*;
#(
    parameter  int W  = 8,
    parameter  int L  = 32,
    localparam int AW = (L > 1) ? $clog2(L) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [AW-1:0]        start_addr,
    input  logic [AW-1:0]        end_addr,
    input  logic                 loop,
    output logic                 busy,
    output logic                 done,
    rom_sample_player_if.master  bus
);

    state_t        state_q,     state_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [W-1:0]  sample_q,    sample_d;
    logic          valid_q,     valid_d;
    logic          done_q,      done_d;
    logic [AW-1:0] cfg_start_q, cfg_start_d;
    logic [AW-1:0] cfg_end_q,   cfg_end_d;
    logic          cfg_loop_q,  cfg_loop_d;

    // Address increment modulo L; L need not be a power of two.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (int'(a) == L - 1) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            cfg_start_q <= '0;
            cfg_end_q   <= '0;
            cfg_loop_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            cfg_start_q <= cfg_start_d;
            cfg_end_q   <= cfg_end_d;
            cfg_loop_q  <= cfg_loop_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        sample_d    = sample_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        cfg_start_d = cfg_start_q;
        cfg_end_d   = cfg_end_q;
        cfg_loop_d  = cfg_loop_q;

        unique case (state_q)
            S_IDLE: begin
                // stop has no meaning here, so start always wins.
                if (start) begin
                    cfg_start_d = start_addr;
                    cfg_end_d   = end_addr;
                    cfg_loop_d  = loop;
                    addr_d      = start_addr;
                    state_d     = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = stop ? S_IDLE : S_CAPTURE;
            end

            S_CAPTURE: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    sample_d = bus.rom_rd_data;
                    valid_d  = 1'b1;
                    state_d  = S_PRESENT;
                end
            end

            S_PRESENT: begin
                // stop overrides a simultaneous handshake: the sample is
                // treated as consumed but the address does not advance.
                if (stop) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (valid_q && bus.sample_ready) begin
                    valid_d = 1'b0;
                    if (addr_q == cfg_end_q) begin
                        if (cfg_loop_q) begin
                            addr_d  = cfg_start_q;
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        addr_d  = next_addr(addr_q);
                        state_d = S_FETCH;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.rom_addr     = addr_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;

endmodule : rom_sample_player
